// File: rtl/step_clock_ctrl.sv
// step_clock_ctrl
//
// Clock-enable controller for the multi-cycle CPU on the Basys3 board.
// It has two modes:
//   - Single-step: a debounced press of CLKButton gives exactly one
//     one-cycle step pulse.
//   - Free-run: while run_mode is set, a divider gives one step pulse
//     every RUN_DIV cycles.
// halt_in from the core suppresses every step pulse.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a press
//                    or a release (>= 2)
//   RUN_DIV          free-run step period in BasysCLK cycles (>= 2)
//
// Ports:
//   BasysCLK    in   system clock, the only clock
//   RST_Button  in   synchronous reset, active low
//   CLKButton   in   raw asynchronous push-button
//   run_mode    in   asynchronous switch: 1 = free-run, 0 = single-step
//   halt_in     in   synchronous CPU halt request
//   step        out  registered one-cycle CPU clock-enable pulse
//   state       out  current FSM state encoding
//   step_count  out  number of steps issued since reset
//
// Build option:
//   STEP_COUNT_EN  when defined, the 16-bit step counter is built.
//                  Otherwise step_count is tied to zero.
module step_clock_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int RUN_DIV         = 4
) (
  input  logic        BasysCLK,
  input  logic        RST_Button,
  input  logic        CLKButton,
  input  logic        run_mode,
  input  logic        halt_in,
  output logic        step,
  output logic [2:0]  state,
  output logic [15:0] step_count
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int DIV_W = $clog2(RUN_DIV);

  localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRESS_DB = 3'd1,
    ST_STEP     = 3'd2,
    ST_WAIT_REL = 3'd3,
    ST_REL_DB   = 3'd4,
    ST_RUN      = 3'd5
  } state_t;

  logic              btn_p0, btn_s;
  logic              run_p0, run_s;
  state_t            state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d, db_inc;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              step_q, step_d;

  // ---- stage p0/p1: two-flop synchronizers for the asynchronous inputs
  always_ff @(posedge BasysCLK) begin
    if (!RST_Button) begin
      btn_p0 <= 1'b0;
      btn_s  <= 1'b0;
      run_p0 <= 1'b0;
      run_s  <= 1'b0;
    end else begin
      btn_p0 <= CLKButton;
      btn_s  <= btn_p0;
      run_p0 <= run_mode;
      run_s  <= run_p0;
    end
  end

  assign db_inc = db_cnt_q + DB_ONE;

  // ---- stage p2: FSM next-state, debounce counter, run divider
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    div_d    = '0;
    step_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d  = ST_PRESS_DB;
          db_cnt_d = '0;
        end
      end
      ST_PRESS_DB: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
        end else begin
          db_cnt_d = db_inc;
          if (db_inc == DB_LAST) state_d = ST_STEP;
        end
      end
      ST_STEP: state_d = ST_WAIT_REL;
      ST_WAIT_REL: begin
        if (!btn_s) begin
          state_d  = ST_REL_DB;
          db_cnt_d = '0;
        end
      end
      ST_REL_DB: begin
        if (btn_s) begin
          state_d = ST_WAIT_REL;
        end else begin
          db_cnt_d = db_inc;
          if (db_inc == DB_LAST) state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!run_s) state_d = btn_s ? ST_WAIT_REL : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The run switch overrides everything except the single STEP cycle,
    // so a step that has already been accepted is never lost.
    if (run_s && (state_q != ST_STEP)) begin
      state_d  = ST_RUN;
      db_cnt_d = '0;
    end

    // The divider only advances while staying in RUN. It is zero on
    // entry, so the first pulse comes after a full period.
    if ((state_q == ST_RUN) && (state_d == ST_RUN))
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;

    // The pulse is registered and lines up with the cycle it belongs to:
    // the STEP cycle, or the RUN cycle where the divider is at its last count.
    step_d = !halt_in &&
             ((state_d == ST_STEP) ||
              ((state_d == ST_RUN) && (div_d == DIV_LAST)));
  end

  always_ff @(posedge BasysCLK) begin
    if (!RST_Button) begin
      state_q  <= ST_IDLE;
      db_cnt_q <= '0;
      div_q    <= '0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      div_q    <= div_d;
      step_q   <= step_d;
    end
  end

  assign step  = step_q;
  assign state = state_q;

`ifdef STEP_COUNT_EN
  logic [15:0] step_count_q;

  // ---- stage p3: step counter, wraps naturally at 16 bits
  always_ff @(posedge BasysCLK) begin
    if (!RST_Button)  step_count_q <= 16'h0000;
    else if (step_q)  step_count_q <= step_count_q + 16'h0001;
  end

  assign step_count = step_count_q;
`else
  assign step_count = 16'h0000;
`endif

endmodule

// File: tb/tb_step_clock_ctrl.sv
module tb_step_clock_ctrl;

  localparam int DB = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn = 1'b0;
  logic        run = 1'b0;
  logic        halt = 1'b0;
  logic        step;
  logic [2:0]  state;
  logic [15:0] step_count;

  step_clock_ctrl #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(RD)) dut (
    .BasysCLK   (clk),
    .RST_Button (rst_n),
    .CLKButton  (btn),
    .run_mode   (run),
    .halt_in    (halt),
    .step       (step),
    .state      (state),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [15:0] model_cnt = 16'h0000;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic logic [15:0] exp_count();
`ifdef STEP_COUNT_EN
    return model_cnt;
`else
    return 16'h0000;
`endif
  endfunction

  // Queue one expected pulse at the given edge index with the count seen
  // while the pulse is high (the counter updates on the following edge).
  function automatic void expect_pulse(input int cyc);
    exp_t e;
    e.cyc = cyc;
    e.cnt = exp_count();
    q.push_back(e);
    model_cnt = model_cnt + 16'h0001;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every step pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (q.size() > 0 && edge_n > q[0].cyc) begin
      total++;
      bad++;
      $display("FAIL missing_step: expected pulse at edge %0d, now edge %0d", q[0].cyc, edge_n);
      void'(q.pop_front());
    end
    if (step === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_step: step=1 at edge %0d, none expected", edge_n);
      end else begin
        mon_e = q.pop_front();
        chk("step_edge", 32'(edge_n), 32'(mon_e.cyc));
        chk("step_count_at_pulse", 32'(step_count), 32'(mon_e.cnt));
      end
    end
  end

  int n0;

  initial begin
    // Reset with inputs toggling
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      btn = ~btn;
      run = ~run;
      tick(1);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_step", 32'(step), 32'd0);
      chk("rst_count", 32'(step_count), 32'd0);
    end
    btn = 1'b0;
    run = 1'b0;
    rst_n = 1'b1;
    tick(1);
    chk("rel_state", 32'(state), 32'd0);
    chk("rel_count", 32'(step_count), 32'd0);
    tick(3);

    // Clean press: pulse 6 edges after the first high sample
    n0 = edge_n;
    btn = 1'b1;
    expect_pulse(n0 + 6);
    tick(20);
    btn = 1'b0;
    tick(20);
    chk("press_state", 32'(state), 32'd0);
    chk("press_count", 32'(step_count), 32'(exp_count()));

    // Bounce: 2 high / 2 low, never leaves IDLE/PRESS_DB
    for (int i = 0; i < 10; i++) begin
      btn = 1'b1;
      tick(1); chk("bounce_state", 32'(state <= 3'd1), 32'd1);
      tick(1); chk("bounce_state", 32'(state <= 3'd1), 32'd1);
      btn = 1'b0;
      tick(1); chk("bounce_state", 32'(state <= 3'd1), 32'd1);
      tick(1); chk("bounce_state", 32'(state <= 3'd1), 32'd1);
    end
    tick(6);
    chk("bounce_idle", 32'(state), 32'd0);
    chk("bounce_count", 32'(step_count), 32'(exp_count()));

    // Run mode for 40 cycles, button held when the switch clears
    n0 = edge_n;
    run = 1'b1;
    for (int k = 0; k < 10; k++) expect_pulse(n0 + 6 + 4 * k);
    tick(3);
    chk("run_entry", 32'(state), 32'd5);
    tick(27);
    btn = 1'b1;
    tick(10);
    run = 1'b0;
    tick(10);
    chk("run_exit_wait_rel", 32'(state), 32'd3);
    tick(10);
    chk("held_wait_rel", 32'(state), 32'd3);
    btn = 1'b0;
    tick(10);
    chk("after_release_idle", 32'(state), 32'd0);
    chk("run_count", 32'(step_count), 32'(exp_count()));
    n0 = edge_n;
    btn = 1'b1;
    expect_pulse(n0 + 6);
    tick(12);
    btn = 1'b0;
    tick(12);
    chk("repress_count", 32'(step_count), 32'(exp_count()));

    // Halt during a clean press
    halt = 1'b1;
    btn = 1'b1;
    tick(20);
    btn = 1'b0;
    tick(20);
    chk("halt_press_state", 32'(state), 32'd0);
    chk("halt_press_count", 32'(step_count), 32'(exp_count()));

    // Halt during run, released after 16 cycles
    n0 = edge_n;
    run = 1'b1;
    tick(16);
    chk("halt_run_count", 32'(step_count), 32'(exp_count()));
    halt = 1'b0;
    for (int k = 0; k < 4; k++) expect_pulse(n0 + 18 + 4 * k);
    tick(12);
    run = 1'b0;
    tick(10);
    chk("halt_run_idle", 32'(state), 32'd0);
    chk("halt_run_after_count", 32'(step_count), 32'(exp_count()));

    // Reset in the middle of a debounce sequence
    btn = 1'b1;
    tick(4);
    rst_n = 1'b0;
    btn = 1'b0;
    tick(2);
    model_cnt = 16'h0000;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_count", 32'(step_count), 32'd0);
    rst_n = 1'b1;
    tick(10);
    chk("midrst_after_state", 32'(state), 32'd0);

`ifdef STEP_COUNT_EN
    // Counter wrap 0xFFFF -> 0x0000
    force dut.step_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.step_count_q;
    model_cnt = 16'hFFFF;
    tick(1);
    chk("wrap_preset", 32'(step_count), 32'h0000FFFF);
    n0 = edge_n;
    btn = 1'b1;
    expect_pulse(n0 + 6);
    tick(12);
    btn = 1'b0;
    tick(12);
    chk("wrap_count", 32'(step_count), 32'h00000000);
`endif

    // Drain any outstanding expectations, bounded
    for (int i = 0; i < 20 && q.size() > 0; i++) tick(1);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/step_clock_ctrl.md
# step_clock_ctrl

Single-step / free-run clock-enable controller for the multi-cycle CPU on the Basys3 board. It debounces the `CLKButton` push-button and emits exactly one CPU step-enable pulse per clean press. In run mode it instead emits a periodic step pulse from a divider. It sits between the board I/O and the CPU core's clock-enable, and honours a halt request from the core.

## Interface
- `DEBOUNCE_CYCLES`, 1000: consecutive stable cycles required to accept a press or a release (≥2).
- `RUN_DIV`, 4: run-mode step period in `BasysCLK` cycles (≥2).
- `BasysCLK`  in  1  system clock, the only clock.
- `RST_Button`  in  1  synchronous, active-low reset.
- `CLKButton`  in  1  raw asynchronous push-button.
- `run_mode`  in  1  asynchronous switch; 1 = free-run, 0 = single-step.
- `halt_in`  in  1  synchronous CPU halt request; suppresses all steps.
- `step`  out  1  one-cycle CPU clock-enable pulse.
- `state`  out  3  current FSM state encoding.
- `step_count`  out  16  steps issued since reset.

## Operation
- `CLKButton` and `run_mode` each pass through a 2-flop synchronizer. `btn_s` and `run_s` are the synchronized values. All decisions use only these.
- FSM states and encodings:
  - IDLE=0
  - PRESS_DB=1
  - STEP=2
  - WAIT_REL=3
  - REL_DB=4
  - RUN=5
- IDLE:
  - `run_s` → RUN.
  - else `btn_s` → PRESS_DB, with the debounce counter cleared to 0.
- PRESS_DB:
  - `btn_s`=0 → IDLE (bounce rejected).
  - Otherwise the counter increments. When the counter equals `DEBOUNCE_CYCLES-1` → STEP.
- STEP:
  - Lasts one cycle, then → WAIT_REL.
  - `step`=1 in this cycle unless `halt_in`=1. A press consumed during halt produces no pulse.
- WAIT_REL: `btn_s`=0 → REL_DB, with the counter cleared.
- REL_DB:
  - `btn_s`=1 → WAIT_REL.
  - Otherwise the counter increments. When it equals `DEBOUNCE_CYCLES-1` → IDLE.
- RUN:
  - Divider counts 0..`RUN_DIV-1` and wraps.
  - `step`=1 in the cycle the divider equals `RUN_DIV-1` and `halt_in`=0. The divider keeps counting during halt.
  - `run_s`=0 → WAIT_REL if `btn_s`=1, else IDLE. The divider clears on exit.
- `run_s` priority: `run_s`=1 in any state other than STEP forces → RUN next cycle, with the debounce counter cleared.
- `step_count`:
  - Increments by 1 on every cycle with `step`=1.
  - 16-bit; wraps 0xFFFF → 0x0000.
- Counter widths are $clog2 of the respective parameter. There is no saturation; the counters compare for equality only.

## Timing
- Reset (`RST_Button`=0 at a rising edge), on the following edge:
  - state=IDLE, `step`=0, `step_count`=0.
  - Synchronizers, debounce counter and divider all cleared.
- Reset mid-operation aborts any debounce or run sequence with no pulse.
- `step` is registered. From the first edge sampling a stable `CLKButton`=1 in IDLE, `step` is high in the cycle following edge `DEBOUNCE_CYCLES+2`, for exactly one cycle.
- Run-mode latency:
  - RUN is entered 3 edges after `run_mode` rises.
  - The first pulse comes `RUN_DIV` cycles after entering RUN.
  - Pulses then repeat every `RUN_DIV` cycles.
- `halt_in` takes effect combinationally on the next registered `step`. There is no latency beyond one register.
- At most one pulse per press, regardless of hold time.

## Configuration
- `STEP_COUNT_EN` defined: `step_count` is implemented as specified.
- `STEP_COUNT_EN` undefined:
  - The counter is not built and `step_count` is tied to 16'h0000.
  - All other behaviour is identical.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `RUN_DIV`=4.
- Reset: hold `RST_Button`=0 for 3 cycles with the button and switch toggling → `state`=0, `step`=0, `step_count`=0 throughout and on release.
- Clean press: button high for 20 cycles, then low for 20 → exactly one `step` pulse, 6 edges after the first high sample. `step_count`=1; state returns to 0.
- Bounce: button pulses of 2 cycles high / 2 cycles low repeated 10 times → no `step`; `state` oscillates 0↔1 only.
- Run mode: `run_mode`=1 for 40 cycles → `step` every 4th cycle, 9–10 pulses, `step_count` matches. Clearing the switch while the button is held → WAIT_REL, and no pulse until the button is released and pressed again.
- Halt: `halt_in`=1 during a clean press and during 16 run cycles → zero pulses and `step_count` unchanged. Deasserting halt → pulses resume on the next divider wrap.
- Wrap (`STEP_COUNT_EN`): force `step_count` to 0xFFFF, issue one press → `step_count`=0x0000. Without the macro → `step_count` stays 0 throughout.
